// File: rtl/gray_code_converter_if.sv
// Handshake bundle for the Gray/binary converter: input word channel and output word channel.
// The slave modport is the converter's view; the master modport is the source/sink side.
interface gray_code_converter_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             step_err;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, step_err
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, step_err
    );
endinterface

// File: rtl/gray_code_converter.sv
// Pipelined Gray<->binary converter with per-word direction and a Gray step-error monitor.
// Gray-to-binary resolves BITS_PER_STAGE bits per stage from the MSB down; binary-to-Gray is done in stage 0.
module gray_code_converter #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_STAGE = 2,
    parameter int CHECK_STEP     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gray_code_converter_if.slave  bus
);
    localparam int LAT = (WIDTH + BITS_PER_STAGE - 1) / BITS_PER_STAGE;

    logic [WIDTH-1:0] r_w_p [LAT];
    logic [LAT-1:0]   r_vld_p;
    logic [LAT-1:0]   r_mode_p;
    logic [LAT-1:0]   r_err_p;

    logic [WIDTH-1:0] w_src [LAT];
    logic [WIDTH-1:0] w_nxt [LAT];
    logic [LAT-1:0]   w_mode_src;
    logic             w_adv;
    logic             w_accept;
    logic             w_err_in;

    // Resolve the Gray bits owned by stage k; higher bits are already binary.
    function automatic logic [WIDTH-1:0] g2b_stage(input logic [WIDTH-1:0] w, input int k);
        logic [WIDTH-1:0] r;
        int hi;
        int lo;
        r  = w;
        hi = WIDTH - 1 - k * BITS_PER_STAGE;
        lo = WIDTH - (k + 1) * BITS_PER_STAGE;
        if (lo < 0) lo = 0;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) r[i] = r[i+1] ^ r[i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] w, input logic mode,
                                                  input int k);
        logic [WIDTH-1:0] r;
        if (!mode)       r = g2b_stage(w, k);
        else if (k == 0) r = w ^ (w >> 1);
        else             r = w;
        return r;
    endfunction

    assign w_adv        = bus.out_ready | ~r_vld_p[LAT-1];
    assign w_accept     = bus.in_valid & w_adv;
    assign bus.in_ready = w_adv;

    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            w_src[k]      = '0;
            w_mode_src[k] = 1'b0;
            w_nxt[k]      = '0;
        end
        w_src[0]      = bus.in_data;
        w_mode_src[0] = bus.in_mode;
        for (int k = 1; k < LAT; k++) begin
            w_src[k]      = r_w_p[k-1];
            w_mode_src[k] = r_mode_p[k-1];
        end
        for (int k = 0; k < LAT; k++) begin
            w_nxt[k] = stage_fn(w_src[k], w_mode_src[k], k);
        end
    end

    generate
        if (CHECK_STEP != 0) begin : g_step
            logic [WIDTH-1:0] r_last_gray;
            logic             r_have_prev;
            logic [WIDTH-1:0] w_diff;

            // More than one differing bit <=> clearing the lowest set bit leaves something.
            assign w_diff   = bus.in_data ^ r_last_gray;
            assign w_err_in = r_have_prev & ~bus.in_mode & ((w_diff & (w_diff - WIDTH'(1))) != '0);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_last_gray <= '0;
                    r_have_prev <= 1'b0;
                end else if (w_accept && !bus.in_mode) begin
                    r_last_gray <= bus.in_data;
                    r_have_prev <= 1'b1;
                end
            end
        end else begin : g_nostep
            assign w_err_in = 1'b0;
        end
    endgenerate

    // Stage registers: control is reset, data words are only loaded on advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p  <= '0;
            r_mode_p <= '0;
            r_err_p  <= '0;
        end else if (w_adv) begin
            r_vld_p[0]  <= w_accept;
            r_mode_p[0] <= w_accept & bus.in_mode;
            r_err_p[0]  <= w_accept & w_err_in;
            for (int k = 1; k < LAT; k++) begin
                r_vld_p[k]  <= r_vld_p[k-1];
                r_mode_p[k] <= r_mode_p[k-1];
                r_err_p[k]  <= r_err_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < LAT; k++) r_w_p[k] <= w_nxt[k];
        end
    end

    assign bus.out_valid = r_vld_p[LAT-1];
    assign bus.out_data  = r_vld_p[LAT-1] ? r_w_p[LAT-1] : '0;
    assign bus.out_mode  = r_mode_p[LAT-1];
    assign bus.step_err  = r_err_p[LAT-1];
endmodule

// File: tb/tb_gray_code_converter.sv
// Bench for gray_code_converter (WIDTH=8, BPS=2): table vectors, stall, exhaustive round trip, mid-flight reset.
module tb_gray_code_converter;
    localparam int LAT = 4;

    typedef struct {
        logic       m;
        logic [7:0] din;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       m;
        logic       e;
        int         acc;
    } sb_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   lat_chk;
    sb_t  q[$];
    vec_t tbl[12];

    gray_code_converter_if #(.WIDTH(8)) bus ();

    gray_code_converter #(
        .WIDTH(8), .BITS_PER_STAGE(2), .CHECK_STEP(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic logic [7:0] b2g(input logic [7:0] b);
        logic [7:0] g;
        for (int i = 0; i < 8; i++) g[i] = (i == 7) ? b[7] : (b[i] ^ b[i+1]);
        return g;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic send(input logic m, input logic [7:0] d, input logic [7:0] ed, input logic ee);
        bit   ok;
        sb_t  s;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_data  = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                s.d = ed; s.m = m; s.e = ee; s.acc = cyc;
                q.push_back(s);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_accept", 32'(ok), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Scoreboard: compare head on every valid output; pop only on emit.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(q[0].d));
                chk("out_mode", 32'(bus.out_mode), 32'(q[0].m));
                chk("step_err", 32'(bus.step_err), 32'(q[0].e));
                if (bus.out_ready) begin
                    if (lat_chk) chk("latency", 32'(cyc - q[0].acc), 32'(LAT));
                    void'(q.pop_front());
                end else begin
                    chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b0, 8'h0C, 8'h08, 1'b0};
        tbl[1]  = '{1'b0, 8'h80, 8'hFF, 1'b1};
        tbl[2]  = '{1'b1, 8'hFF, 8'h80, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 8'h01, 8'h01, 1'b0};
        tbl[5]  = '{1'b0, 8'h03, 8'h02, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 8'h00, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 8'h05, 8'h07, 1'b0};
        tbl[9]  = '{1'b0, 8'h01, 8'h01, 1'b0};
        tbl[10] = '{1'b0, 8'hFF, 8'hAA, 1'b1};
        tbl[11] = '{1'b1, 8'h80, 8'hC0, 1'b0};

        reset_n       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        lat_chk       = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_mode",  32'(bus.out_mode),  32'd0);
        chk("rst_step_err",  32'(bus.step_err),  32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 12; i++) send(tbl[i].m, tbl[i].din, tbl[i].exp_d, tbl[i].exp_e);
        drain();

        lat_chk = 1'b0;
        fork
            begin
                logic [7:0] d;
                for (int j = 0; j < 6; j++) begin
                    d = 8'($urandom_range(0, 255));
                    send(1'b1, d, b2g(d), 1'b0);
                end
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = bus.out_valid;
                end
                chk("stall_saw_valid", 32'(seen), 32'd1);
                @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        do_reset();
        for (int i = 0; i < 256; i++) send(1'b1, 8'(i), b2g(8'(i)), 1'b0);
        for (int i = 0; i < 256; i++) send(1'b0, b2g(8'(i)), 8'(i), 1'b0);
        drain();

        bus.out_ready = 1'b0;
        send(1'b1, 8'h01, 8'h01, 1'b0);
        send(1'b1, 8'h02, 8'h03, 1'b0);
        send(1'b1, 8'h03, 8'h02, 1'b0);
        @(posedge clk);
        #1;
        chk("inflight_valid", 32'(bus.out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.out_ready = 1'b1;
        send(1'b0, 8'hFF, 8'hAA, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_code_converter.md
Name: gray_code_converter

Overview:
Parametrised, pipelined Gray/binary converter for counter and ADC/TDC code paths. It generalises the fixed 8-bit Gray-to-binary stage to any width, with a runtime direction select and a valid/ready handshake. It adds a Gray step-error monitor that flags non-unit-distance jumps between consecutive Gray words. It sits between Gray-coded counters/samplers and downstream binary arithmetic, or in front of Gray-encoded CDC crossings.

Parameters:
WIDTH, 8, data width in bits (>=2)
BITS_PER_STAGE, 2, bits resolved per pipeline stage in Gray-to-binary mode (1..WIDTH)
CHECK_STEP, 1, 1 = step-error monitor present, 0 = step_err tied to 0

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream
in_valid  input  1  input word valid
in_ready  output  1  converter accepts the word this cycle
in_data  input  WIDTH  input code word
in_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray; sampled with the word
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts the word
out_data  output  WIDTH  converted word
out_mode  output  1  mode that travelled with the word
step_err  output  1  qualified by out_valid; the word is Gray and is a >1-bit jump from the previous accepted Gray word

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk and reset_n. Reset clears all pipeline valid bits, out_data, out_mode, step_err and the step-monitor history. in_ready is 1 from the first cycle after reset release.
- LAT = ceil(WIDTH/BITS_PER_STAGE) register stages. Latency is LAT cycles in both modes when unstalled. WIDTH=8, BPS=2 gives LAT=4.
- Accept happens when in_valid & in_ready. Emit happens when out_valid & out_ready.
- Global advance: adv = out_ready | ~out_valid, and in_ready = adv. When adv=0, all stages hold data and valid bits. Bubbles are not compressed.
- out_data, out_mode and step_err stay stable while out_valid=1 and out_ready=0.
- Gray-to-binary (mode 0):
  - b[W-1] = g[W-1]
  - b[i] = b[i+1] ^ g[i]
  - Stage k resolves bits W-1-k*BPS down to max(0, W-(k+1)*BPS). Each stage carries the partial binary result plus the unresolved Gray bits. The last stage may resolve fewer bits.
- Binary-to-Gray (mode 1):
  - g = b ^ (b >> 1), computed in stage 0.
  - Remaining stages pass the word through, so latency equals LAT.
- Mode is per word. Mixed-mode streams are legal back-to-back with no bubble.
- Step monitor (CHECK_STEP=1):
  - It evaluates on accept of a mode-0 word. err = (popcount(in_data ^ last_gray) > 1) & have_prev.
  - After evaluation, last_gray takes in_data and have_prev is set to 1.
  - A zero-distance (repeated) word is not an error.
  - Mode-1 words neither update nor consult history, and their step_err is 0.
  - The flag travels with its word through the pipe.
  - The first mode-0 word after reset has step_err=0.
- Reset mid-operation: all in-flight words are discarded, out_valid falls asynchronously, and history is cleared.
- in_valid with in_ready=0: the word is not consumed. The source holds it, and the monitor does not update.

Test Plan:
- WIDTH=8, BPS=2, out_ready=1; mode 0, in_data=0x0C on cycle 0 → out_valid on cycle 4, out_data=0x08, step_err=0.
- Mode 0, 0x80 then mode 1, 0xFF on consecutive cycles → outputs 0xFF (out_mode=0) then 0x80 (out_mode=1) on consecutive cycles, 4 cycles after each input.
- Mode 0 stream 0x00, 0x01, 0x03, 0x00 → step_err on outputs is 0, 0, 0, 1.
- Stall: send 6 back-to-back words, hold out_ready=0 for 5 cycles once out_valid=1 → in_ready=0 during the stall, the output stays stable, no word is lost or duplicated, and order is preserved.
- Exhaustive: all 256 binary values in mode 1, then the results fed back in mode 0 → round-trip equality. The sequential Gray sequence gives step_err=0 throughout.
- Assert reset_n low with 3 words in flight → out_valid=0 immediately. After release, the next first mode-0 word 0xFF gives out_data=0xAA and step_err=0.
